priority_grant_decoder: RTL and testbench

PRIORITY_GRANT_DECODER -- requirements
Module: priority_grant_decoder

---
 rtl/priority_grant_decoder.sv | 117 +++++++++++
 tb/tb_priority_grant_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/priority_grant_decoder.sv
// Grant decoder: turns an encoded request index into a registered one-hot grant,
// with a one-entry pending buffer and a forced release after TIMEOUT grant cycles.
//
// state | meaning
// IDLE  | no grant held, g0..g3 all zero, waiting for v
// GRANT | one grant held, counter running, pending buffer active
module priority_grant_decoder #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic y1,
  input  logic y0,
  input  logic v,
  input  logic ack,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic busy,
  output logic pend,
  output logic drop,
  output logic timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] pend_idx;
  logic       pend_q;
  logic [7:0] cnt;
  logic       drop_q;
  logic       timeout_q;

  logic [1:0] req_idx;
  logic       at_limit;
  logic       grant_end;

  assign req_idx   = {y1, y0};
  assign at_limit  = (cnt == CNT_LAST);
  assign grant_end = ack || at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      grant_idx <= 2'd0;
      pend_idx  <= 2'd0;
      pend_q    <= 1'b0;
      cnt       <= 8'd0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (v) begin
            state     <= GRANT;
            grant     <= 4'b0001 << req_idx;
            grant_idx <= req_idx;
            cnt       <= 8'd0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            // ack wins over the limit, so only a pure limit hit reports a timeout
            timeout_q <= !ack;
            cnt       <= 8'd0;
            if (pend_q) begin
              grant     <= 4'b0001 << pend_idx;
              grant_idx <= pend_idx;
              if (v && (req_idx != pend_idx)) begin
                pend_idx <= req_idx;
                pend_q   <= 1'b1;
              end else begin
                pend_q <= 1'b0;
              end
            end else if (v) begin
              grant     <= 4'b0001 << req_idx;
              grant_idx <= req_idx;
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (v && (req_idx != grant_idx) && !(pend_q && (req_idx == pend_idx))) begin
              if (!pend_q) begin
                pend_idx <= req_idx;
                pend_q   <= 1'b1;
              end else begin
                drop_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

  assign {g3, g2, g1, g0} = grant;
  assign busy    = (state == GRANT);
  assign pend    = pend_q;
  assign drop    = drop_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Bench for priority_grant_decoder: directed scenarios followed by random traffic,
// each cycle compared against a queue-based model of the grant/pending rules.
module tb_priority_grant_decoder;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst, y1, y0, v, ack;
  logic g0, g1, g2, g3, busy, pend, drop, timeout;

  int total = 0;
  int bad   = 0;

  // model state: current grant index (-1 when idle), cycles already held, pending queue
  int m_cur;
  int m_held;
  int m_q[$];
  bit m_drop, m_to;

  priority_grant_decoder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .y1(y1), .y0(y0), .v(v), .ack(ack),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3),
    .busy(busy), .pend(pend), .drop(drop), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic bit in_queue(int idx);
    foreach (m_q[i]) if (m_q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit vv, input int yy, input bit aa);
    m_drop = 1'b0;
    m_to   = 1'b0;
    if (r) begin
      m_cur = -1; m_held = 0; m_q.delete();
    end else if (m_cur < 0) begin
      if (vv) begin m_cur = yy; m_held = 1; end
    end else if (aa || m_held >= TO) begin
      m_to = !aa;
      if (m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_held = 1;
        if (vv && yy != m_cur) m_q.push_back(yy);
      end else if (vv) begin
        m_cur = yy; m_held = 1;
      end else begin
        m_cur = -1; m_held = 0;
      end
    end else begin
      m_held++;
      if (vv && yy != m_cur && !in_queue(yy)) begin
        if (m_q.size() < 1) m_q.push_back(yy);
        else m_drop = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit vv, input int yy, input bit aa);
    logic [3:0] eg;
    rst = r; v = vv; {y1, y0} = 2'(yy); ack = aa;
    @(posedge clk);
    model_step(r, vv, yy, aa);
    #1;
    eg = (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0000;
    check("grant",   {g3, g2, g1, g0}, eg);
    check("busy",    {3'b0, busy},    {3'b0, m_cur >= 0});
    check("pend",    {3'b0, pend},    {3'b0, m_q.size() > 0});
    check("drop",    {3'b0, drop},    {3'b0, m_drop});
    check("timeout", {3'b0, timeout}, {3'b0, m_to});
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; y1 = 1'b0; y0 = 1'b0; ack = 1'b0;
    m_cur = -1; m_held = 0;
    tick(1, 0, 0, 0);
    tick(1, 1, 3, 1);

    // basic grant and ack release; ack in idle ignored
    tick(0, 0, 0, 1);
    tick(0, 1, 2, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);

    // back-to-back through the pending buffer
    tick(0, 1, 1, 0);
    tick(0, 1, 3, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // overflow, then merge with current grant and with pending index
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 2, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // timeout: held exactly TO cycles, then pulse and idle
    tick(0, 1, 3, 0);
    repeat (TO + 2) tick(0, 0, 0, 0);

    // ack on the last counter value: normal release, no pulse
    tick(0, 1, 1, 0);
    repeat (TO - 1) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);

    // end cycle with pending plus an incoming request refills the buffer
    tick(0, 1, 0, 0);
    tick(0, 1, 2, 0);
    tick(0, 1, 3, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);

    // reset mid-grant with pending, then immediate request
    tick(0, 1, 2, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 3, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
